// File: rtl/fabric_pkg.sv
// Shared fabric definitions: tile FSM states and bitstream geometry helpers.
// The bitstream generator uses the same helpers so field offsets never drift.
package fabric_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } tile_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of one crossbar select field; never narrower than one bit.
    function automatic int calc_sw(input int i, input int n);
        int w;
        w = clog2(i + n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_bb(input int i, input int n, input int k);
        return k * calc_sw(i, n) + (1 << k) + 1;
    endfunction

    function automatic int sel_off(input int i, input int n, input int k_idx);
        return k_idx * calc_sw(i, n);
    endfunction

    function automatic int lut_off(input int i, input int n, input int k);
        return k * calc_sw(i, n);
    endfunction

    function automatic int regsel_off(input int i, input int n, input int k);
        return calc_bb(i, n, k) - 1;
    endfunction

endpackage

// File: rtl/ble_cell.sv
// One basic logic element: K crossbar muxes, 2^K-entry LUT, enabled FF and
// registered/combinational output select.
module ble_cell
    import fabric_pkg::*;
#(
    parameter int I = 4,
    parameter int N = 2,
    parameter int K = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [calc_bb(I,N,K)-1:0]   i_cfg,
    input  logic                        i_cfg_done,
    input  logic                        i_en,
    input  logic                        i_clr,
    input  logic [I-1:0]                i_tile_in,
    input  logic [N-1:0]                i_fb,
    output logic                        o_q,
    output logic                        o_out
);
    localparam int SW     = calc_sw(I, N);
    localparam int NSRC   = 1 << SW;
    localparam int LUT_W  = 1 << K;
    localparam int LUT_LO = lut_off(I, N, K);
    localparam int RS_BIT = regsel_off(I, N, K);

    logic [NSRC-1:0]  w_src;
    logic [K-1:0]     w_idx;
    logic [LUT_W-1:0] w_lut;
    logic             w_lut_out;
    logic             w_regsel;
    logic             r_q;

    // Source vector is padded to 2^SW so out-of-range selects read constant 0.
    always_comb begin
        w_src            = '0;
        w_src[I-1:0]     = i_tile_in;
        w_src[I+N-1:I]   = i_fb;
    end

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < K; k++) begin
            w_idx[k] = w_src[i_cfg[sel_off(I, N, k) +: SW]];
        end
    end

    assign w_lut     = i_cfg[LUT_LO +: LUT_W];
    assign w_lut_out = w_lut[w_idx];
    assign w_regsel  = i_cfg[RS_BIT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_en && i_cfg_done) begin
            r_q <= w_lut_out;
        end
    end

    assign o_q   = r_q;
    assign o_out = i_cfg_done ? (w_regsel ? r_q : w_lut_out) : 1'b0;

endmodule

// File: rtl/cfg_lut_tile.sv
// Configurable LUT tile: serial shadow-chain load with even parity and atomic
// commit. Define CFG_TILE_READBACK_EN to add the cfg_rb_bit readback port.
module cfg_lut_tile
    import fabric_pkg::*;
#(
    parameter int I = 4,
    parameter int N = 2,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic         ble_en,
    input  logic [I-1:0] tile_in,
    output logic [N-1:0] tile_out,
`ifdef CFG_TILE_READBACK_EN
    output logic         cfg_rb_bit,
`endif
    output tile_state_e  dbg_state
);
    localparam int SW       = calc_sw(I, N);
    localparam int BB       = calc_bb(I, N, K);
    localparam int CFG_BITS = N * BB;
    localparam int CW       = clog2(CFG_BITS + 1);

    tile_state_e         r_state;
    tile_state_e         w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_par;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic                r_done;
    logic                r_err;
    logic [N-1:0]        w_q;

    logic w_in_load;
    logic w_accept;
    logic w_last;
    logic w_commit;
    logic w_fail;

    // cfg_start wins over a coincident cfg_valid: that bit is discarded.
    assign w_in_load = (r_state == LOAD);
    assign w_accept  = w_in_load && cfg_valid && !cfg_start;
    assign w_last    = (r_cnt == CW'(CFG_BITS));
    assign w_commit  = w_accept && w_last && (cfg_bit == r_par);
    assign w_fail    = w_accept && w_last && (cfg_bit != r_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UNCFG;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (cfg_start) begin
            w_next = LOAD;
        end else if (w_commit) begin
            w_next = RUN;
        end else if (w_fail) begin
            w_next = ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_shadow <= '0;
            r_active <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (cfg_start) begin
            r_cnt <= '0;
            r_par <= 1'b0;
        end else if (w_accept && !w_last) begin
            r_shadow[r_cnt] <= cfg_bit;
            r_par           <= r_par ^ cfg_bit;
            r_cnt           <= r_cnt + 1'b1;
        end else if (w_commit) begin
            r_active <= r_shadow;
            r_done   <= 1'b1;
            r_err    <= 1'b0;
        end else if (w_fail) begin
            r_err <= 1'b1;
        end
    end

    assign cfg_ready = w_in_load;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign dbg_state = r_state;

`ifdef CFG_TILE_READBACK_EN
    // Old configuration streams out in step with the new one streaming in.
    assign cfg_rb_bit = (w_in_load && (r_cnt < CW'(CFG_BITS))) ? r_active[r_cnt] : 1'b0;
`endif

    for (genvar b = 0; b < N; b++) begin : g_ble
        ble_cell #(
            .I(I),
            .N(N),
            .K(K)
        ) u_ble (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_cfg      (r_active[b*BB +: BB]),
            .i_cfg_done (r_done),
            .i_en       (ble_en),
            .i_clr      (w_commit),
            .i_tile_in  (tile_in),
            .i_fb       (w_q),
            .o_q        (w_q[b]),
            .o_out      (tile_out[b])
        );
    end

endmodule

// File: tb/tb_cfg_lut_tile.sv
// Directed bench for cfg_lut_tile: serial loads, parity failure, restart,
// async reset abort and table-driven combinational checks.
module tb_cfg_lut_tile;
    import fabric_pkg::*;

    localparam int NBITS = 58;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_bit;
    logic        cfg_ready;
    logic        cfg_done;
    logic        cfg_err;
    logic        ble_en;
    logic [3:0]  tile_in;
    logic [1:0]  tile_out;
    tile_state_e dbg_state;
`ifdef CFG_TILE_READBACK_EN
    logic        cfg_rb_bit;
`endif

    cfg_lut_tile #(.I(4), .N(2), .K(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .ble_en    (ble_en),
        .tile_in   (tile_in),
        .tile_out  (tile_out),
`ifdef CFG_TILE_READBACK_EN
        .cfg_rb_bit(cfg_rb_bit),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic trk    = 1'b0;
    logic m_q1   = 1'b0;
    logic m_done = 1'b0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0] tin;
        logic [1:0] exp;
    } vec_t;

    vec_t tab_a[8];
    vec_t tab_b[6];

    logic [NBITS-1:0] cfg_a;
    logic [NBITS-1:0] cfg_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [28:0] ble_word(input logic [2:0] s0, input logic [2:0] s1,
                                             input logic [2:0] s2, input logic [2:0] s3,
                                             input logic [15:0] lut, input logic rs);
        return {rs, lut, s3, s2, s1, s0};
    endfunction

    // Advance one clock; optionally track the BLE1 toggle model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (trk) begin
            if (ble_en) m_q1 = ~m_q1;
            chk("toggle_run", {31'd0, tile_out[1]}, {31'd0, m_q1});
        end
    endtask

    task automatic start_load(input logic v, input logic b);
        cfg_start = 1'b1;
        cfg_valid = v;
        cfg_bit   = b;
        tick();
        cfg_start = 1'b0;
        chk("start_state", {30'd0, dbg_state}, {30'd0, LOAD});
        chk("start_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    task automatic send_partial(input logic [NBITS-1:0] data, input int n);
        for (int j = 0; j < n; j++) begin
            cfg_valid = 1'b1;
            cfg_bit   = data[j];
            tick();
        end
    endtask

    task automatic load(input logic [NBITS-1:0] data, input logic flip);
        for (int j = 0; j <= NBITS; j++) begin
            cfg_valid = 1'b1;
            cfg_bit   = (j < NBITS) ? data[j] : ((^data) ^ flip);
            chk("ready_in_load", {31'd0, cfg_ready}, 32'd1);
            chk("done_hold", {31'd0, cfg_done}, {31'd0, m_done});
            if (!m_done) chk("out_precommit", {30'd0, tile_out}, 32'd0);
            tick();
        end
        cfg_valid = 1'b0;
        chk("ready_drop", {31'd0, cfg_ready}, 32'd0);
    endtask

    task automatic run_table_a();
        for (int i = 0; i < 8; i++) begin
            tile_in = tab_a[i].tin;
            #1;
            chk("table_a", {30'd0, tile_out}, {30'd0, tab_a[i].exp});
        end
    endtask

    initial begin
        // BLE0: AND of tile_in[1:0]; BLE1: registered toggle via own feedback.
        cfg_a = {ble_word(3'd5, 3'd7, 3'd7, 3'd7, 16'h0001, 1'b1),
                 ble_word(3'd0, 3'd1, 3'd7, 3'd7, 16'h0008, 1'b0)};
        // BLE0: OR of tile_in[3:2]; BLE1: combinational copy of BLE0 q.
        cfg_b = {ble_word(3'd4, 3'd7, 3'd7, 3'd7, 16'h0002, 1'b0),
                 ble_word(3'd2, 3'd3, 3'd7, 3'd7, 16'h000E, 1'b0)};

        tab_a[0] = '{4'b0000, 2'b00};
        tab_a[1] = '{4'b0001, 2'b00};
        tab_a[2] = '{4'b0010, 2'b00};
        tab_a[3] = '{4'b0011, 2'b01};
        tab_a[4] = '{4'b1100, 2'b00};
        tab_a[5] = '{4'b0111, 2'b01};
        tab_a[6] = '{4'b1110, 2'b00};
        tab_a[7] = '{4'b1111, 2'b01};

        tab_b[0] = '{4'b0000, 2'b00};
        tab_b[1] = '{4'b0100, 2'b01};
        tab_b[2] = '{4'b1000, 2'b01};
        tab_b[3] = '{4'b0011, 2'b00};
        tab_b[4] = '{4'b1100, 2'b01};
        tab_b[5] = '{4'b1011, 2'b01};

        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        ble_en    = 1'b0;
        tile_in   = 4'b1111;

        // Reset state
        #2;
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_out", {30'd0, tile_out}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, UNCFG});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("uncfg_ignore_valid", {30'd0, dbg_state}, {30'd0, UNCFG});
        chk("uncfg_out", {30'd0, tile_out}, 32'd0);

        // Case 1: full valid load
        start_load(1'b0, 1'b0);
        load(cfg_a, 1'b0);
        m_done = 1'b1;
        m_q1   = 1'b0;
        chk("c1_done", {31'd0, cfg_done}, 32'd1);
        chk("c1_err", {31'd0, cfg_err}, 32'd0);
        chk("c1_state", {30'd0, dbg_state}, {30'd0, RUN});

        // Case 2: combinational AND on BLE0
        run_table_a();

        // Case 3: BLE1 toggle, then hold
        tile_in = 4'b0000;
        ble_en  = 1'b1;
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        while (exp_q.size() > 0) begin
            logic [1:0] e;
            tick();
            e = exp_q.pop_front();
            chk("c3_toggle", {30'd0, tile_out}, {30'd0, e});
        end
        ble_en = 1'b0;
        repeat (2) begin
            tick();
            chk("c3_hold", {31'd0, tile_out[1]}, 32'd1);
        end
        m_q1 = 1'b1;

        // Case 4: bad parity while toggle keeps running
        ble_en = 1'b1;
        trk    = 1'b1;
        start_load(1'b0, 1'b0);
        load(cfg_b, 1'b1);
        tick();
        trk    = 1'b0;
        ble_en = 1'b0;
        chk("c4_err", {31'd0, cfg_err}, 32'd1);
        chk("c4_done", {31'd0, cfg_done}, 32'd1);
        chk("c4_state", {30'd0, dbg_state}, {30'd0, ERR});
        for (int i = 0; i < 8; i++) begin
            tile_in = tab_a[i].tin;
            #1;
            chk("c4_old_cfg", {31'd0, tile_out[0]}, {31'd0, tab_a[i].exp[0]});
        end

        // Case 5: restart after 20 bits with coincident valid
        start_load(1'b0, 1'b0);
        send_partial(cfg_a, 20);
        start_load(1'b1, 1'b1);
        load(cfg_b, 1'b0);
        chk("c5_done", {31'd0, cfg_done}, 32'd1);
        chk("c5_err_clr", {31'd0, cfg_err}, 32'd0);
        chk("c5_state", {30'd0, dbg_state}, {30'd0, RUN});
        for (int i = 0; i < 6; i++) begin
            tile_in = tab_b[i].tin;
            #1;
            chk("table_b", {30'd0, tile_out}, {30'd0, tab_b[i].exp});
        end

        // Feedback: BLE1 follows BLE0 flip-flop one edge later
        ble_en  = 1'b1;
        tile_in = 4'b0100;
        tick();
        chk("fb_set", {30'd0, tile_out}, 32'd3);
        tile_in = 4'b0000;
        tick();
        chk("fb_clr", {30'd0, tile_out}, 32'd0);
        ble_en = 1'b0;

        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("run_ignore_valid", {30'd0, dbg_state}, {30'd0, RUN});

        // Case 6: async reset mid-load
        tile_in = 4'b0100;
        start_load(1'b0, 1'b0);
        send_partial(cfg_a, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c6_out", {30'd0, tile_out}, 32'd0);
        chk("c6_ready", {31'd0, cfg_ready}, 32'd0);
        chk("c6_done", {31'd0, cfg_done}, 32'd0);
        chk("c6_err", {31'd0, cfg_err}, 32'd0);
        chk("c6_state", {30'd0, dbg_state}, {30'd0, UNCFG});
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("c6_uncfg_ready", {31'd0, cfg_ready}, 32'd0);
        chk("c6_uncfg_state", {30'd0, dbg_state}, {30'd0, UNCFG});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
